// File: rtl/priority_encoder_drain.sv
// Captures a multi-hot request vector and serialises its set bits into indices,
// one per accepted output beat, lowest-first or highest-first.
module priority_encoder_drain #(
  parameter int N         = 8,
  parameter int W         = $clog2(N),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_vec,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         none,
  output logic [W:0]   count
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pending_q;
  logic [W:0]   count_q;
  logic         none_q;

  logic [W-1:0] enc_idx;
  logic [W:0]   in_pop;
  logic         single;
  logic         capture;
  logic         accept;
  logic [N-1:0] clear_mask;

  // The last matching bit in loop order wins, giving the requested priority.
  always_comb begin
    enc_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++)
        if (pending_q[i]) enc_idx = W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (pending_q[i]) enc_idx = W'(i);
    end
  end

  always_comb begin
    in_pop = '0;
    for (int i = 0; i < N; i++)
      in_pop = in_pop + (W+1)'(in_vec[i]);
  end

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign single     = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);
  assign capture    = (state_q == IDLE) && in_valid;
  assign accept     = (state_q == DRAIN) && out_ready;
  assign clear_mask = N'(1) << enc_idx;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && (in_vec != '0)) state_d = DRAIN;
      DRAIN:   if (out_ready && single) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      none_q  <= capture && (in_vec == '0);
      if (capture) begin
        pending_q <= in_vec;
        count_q   <= in_pop;
      end else if (accept) begin
        pending_q <= pending_q & ~clear_mask;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DRAIN);
  assign out_idx   = enc_idx;
  assign out_last  = (state_q == DRAIN) && single;
  assign none      = none_q;
  assign count     = count_q;

endmodule
